// File: rtl/rrp_addsub_pipe.sv
// Multi-lane radix-RADIX signed-digit adder/subtractor, two-stage pipeline with
// valid/ready flow control. Stage 1 holds interim digits w and transfers t;
// stage 2 holds the final digit vectors.
module rrp_addsub_pipe #(
  parameter int unsigned RADIX = 8,
  parameter int unsigned WIDTH = 5,
  parameter int unsigned LANES = 2
) (
  input  logic                                               clock,
  input  logic                                               reset_n,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [LANES-1:0]                                   in_sub,
  input  logic [LANES*(($clog2(RADIX)+1)*WIDTH)-1:0]         x_in,
  input  logic [LANES*(($clog2(RADIX)+1)*WIDTH)-1:0]         y_in,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [LANES*(($clog2(RADIX)+1)*(WIDTH+1))-1:0]     s_out
);

  localparam int unsigned D  = $clog2(RADIX) + 1;
  localparam int unsigned N  = D * WIDTH;
  localparam int unsigned SW = N + D;

  // Thresholds in the (D+1)-bit signed domain of the digit-pair sum.
  localparam logic signed [D:0] AS    = (D+1)'(RADIX - 1);
  localparam logic signed [D:0] NEG_A = -AS;
  localparam logic signed [D:0] RS    = (D+1)'(RADIX);

  if (!((RADIX >= 4) && ((RADIX & (RADIX - 1)) == 0))) begin : g_bad_radix
    $error("rrp_addsub_pipe: RADIX must be a power of two and at least 4");
  end

  // Transfer digit encoding: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0.
  function automatic logic [D-1:0] t_ext(input logic [1:0] t);
    return {{(D-2){t[1]}}, t};
  endfunction

  logic                     s1_valid_d, s1_valid_q;
  logic                     s2_valid_d, s2_valid_q;
  logic [LANES*WIDTH*D-1:0] w_d, w_q;
  logic [LANES*WIDTH*2-1:0] t_d, t_q;
  logic [LANES*SW-1:0]      s_d, s_q;
  logic                     adv1, adv2;

  logic signed [D:0] x_e, y_e, p_e, w_e;
  logic [1:0]        t_e;

  // Handshake: stage 2 drains when downstream takes it or it is empty.
  always_comb begin
    in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    adv1     = in_valid && in_ready;
    adv2     = s1_valid_q && (!s2_valid_q || out_ready);
    s1_valid_d = adv1 || (s1_valid_q && !adv2);
    s2_valid_d = adv2 || (s2_valid_q && !out_ready);
  end

  // Stage 1 next state: per-digit sum split into transfer and interim digit.
  always_comb begin
    w_d = w_q;
    t_d = t_q;
    x_e = '0;
    y_e = '0;
    p_e = '0;
    w_e = '0;
    t_e = 2'b00;
    if (adv1) begin
      for (int k = 0; k < LANES; k++) begin
        for (int i = 0; i < WIDTH; i++) begin
          x_e = {x_in[k*N + i*D + D-1], x_in[k*N + i*D +: D]};
          y_e = {y_in[k*N + i*D + D-1], y_in[k*N + i*D +: D]};
          if (in_sub[k]) begin
            y_e = -y_e;
          end
          p_e = x_e + y_e;
          if (p_e >= AS) begin
            t_e = 2'b01;
            w_e = p_e - RS;
          end else if (p_e <= NEG_A) begin
            t_e = 2'b11;
            w_e = p_e + RS;
          end else begin
            t_e = 2'b00;
            w_e = p_e;
          end
          w_d[(k*WIDTH + i)*D +: D] = w_e[D-1:0];
          t_d[(k*WIDTH + i)*2 +: 2] = t_e;
        end
      end
    end
  end

  // Stage 2 next state: absorb the transfer from the next-lower digit.
  always_comb begin
    s_d = s_q;
    if (adv2) begin
      for (int k = 0; k < LANES; k++) begin
        s_d[k*SW +: D] = w_q[(k*WIDTH)*D +: D];
        for (int i = 1; i < WIDTH; i++) begin
          s_d[k*SW + i*D +: D] = w_q[(k*WIDTH + i)*D +: D]
                               + t_ext(t_q[(k*WIDTH + i - 1)*2 +: 2]);
        end
        s_d[k*SW + WIDTH*D +: D] = t_ext(t_q[(k*WIDTH + WIDTH - 1)*2 +: 2]);
      end
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      w_q        <= '0;
      t_q        <= '0;
      s_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      w_q        <= w_d;
      t_q        <= t_d;
      s_q        <= s_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign s_out     = s_q;

endmodule
